mapper_ctx_switch: RTL
======================

Name: mapper_ctx_switch

Overview:
- Sequencer for hypervisor entry and exit around the 4510 user mapper registers (A, X, Y, Z of map set 0).
- On entry: reads the four user map registers into shadow storage, then writes a fixed hypervisor mapping through the mapper's hypervisor write port.
- On exit: writes the shadow values back.
- Sits between the hypervisor controller and the mapper FSM's hypervisor_load_user_reg / map_reg_write_sel / data path.

Parameters:
- HYP_A, 8'h00, hypervisor map A value (low-set offset [15:8])
- HYP_X, 8'h00, hypervisor map X value ({enables[3:0], offset[19:16]} low set)
- HYP_Y, 8'h00, hypervisor map Y value (high-set offset [15:8])
- HYP_Z, 8'h3F, hypervisor map Z value ({enables[3:0], offset[19:16]} high set)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- ready  in  1  CPU ready; sequencer steps only when high
- map_busy  in  1  mapper "map" flag (MAP instruction in progress); sequencer stalls while high
- enter_req  in  1  single-cycle request: save user map, load hypervisor map
- exit_req  in  1  single-cycle request: restore user map
- rd_data  in  8  mapper register readback for the register selected by rd_sel
- rd_sel  out  2  register select for readback (3=A, 2=X, 1=Y, 0=Z)
- wr_en  out  1  drives hypervisor_load_user_reg
- wr_sel  out  2  drives map_reg_write_sel (3=A, 2=X, 1=Y, 0=Z)
- wr_data  out  8  write data to the mapper
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on sequence completion
- err  out  1  one-cycle pulse when a request is rejected
- ctx_saved  out  1  shadow holds a valid user context
- shadow_a, shadow_x, shadow_y, shadow_z  out  8 each  saved user values, for the monitor

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: state=IDLE, idx=3, all shadow regs 8'h00, ctx_saved=0, done=0, err=0. Combinational outputs at reset: wr_en=0, busy=0, rd_sel=0, wr_sel=0, wr_data=0.
- step = ready & ~map_busy.
- States:
  - IDLE
  - SAVE
  - LOAD
  - RESTORE
  - DONE
- Index: 2-bit counter idx, counts down 3→0 within each of SAVE, LOAD and RESTORE. It advances only on a step cycle and reloads to 3 on every state change.
- IDLE:
  - enter_req & ~ctx_saved → SAVE.
  - exit_req & ctx_saved → RESTORE.
  - enter_req with ctx_saved=1 → stay in IDLE, err pulse next cycle.
  - exit_req with ctx_saved=0 → stay in IDLE, err pulse next cycle.
  - enter_req and exit_req together → enter has priority; exit is dropped silently.
- SAVE:
  - rd_sel=idx (combinational).
  - On step, shadow[idx] <= rd_data.
  - Step with idx=0 → LOAD.
- LOAD:
  - wr_en=step, wr_sel=idx, wr_data=HYP_[idx].
  - Step with idx=0 → DONE, and ctx_saved <= 1.
- RESTORE:
  - wr_en=step, wr_sel=idx, wr_data=shadow[idx].
  - Step with idx=0 → DONE, and ctx_saved <= 0.
- DONE: done=1 for exactly one cycle → IDLE.
- Requests arriving while busy are ignored. No err pulse and no queuing.
- wr_en is never asserted while map_busy=1 or ready=0. The mapper's own map==0 gate is therefore never relied on.
- Latency with ready=1 and map_busy=0 throughout:
  - Enter: request sampled at edge 0; SAVE occupies cycles 1–4, LOAD cycles 5–8, done high in cycle 9.
  - Exit: RESTORE occupies cycles 1–4, done high in cycle 5.
- Stall: any cycle with step=0 freezes idx, shadow and ctx_saved, and holds rd_sel/wr_sel/wr_data stable with wr_en=0.
- Reset mid-sequence returns all state to reset values. This includes ctx_saved=0, so a partial save is discarded and a partial restore is not resumed.
- Outside the active state, wr_sel, wr_data and rd_sel drive 0.

Test Plan:
- Enter, no stalls: mapper holds A=12, X=34, Y=56, Z=78 → shadow_a..z = 12, 34, 56, 78; wr_en in cycles 5–8 with (sel, data) = (3,00), (2,00), (1,00), (0,3F); done in cycle 9; ctx_saved=1.
- Exit after that enter → wr_en in cycles 1–4 with (3,12), (2,34), (1,56), (0,78); done in cycle 5; ctx_saved=0.
- map_busy=1 for 3 cycles starting in LOAD idx=2 → wr_en=0 and wr_sel=2 held for those 3 cycles; the sequence resumes and done arrives 3 cycles late.
- Illegal requests: exit_req with ctx_saved=0, and enter_req with ctx_saved=1 → each gives one err pulse; no wr_en; state stays IDLE.
- enter_req and exit_req asserted together in IDLE with ctx_saved=0 → SAVE entered; no err pulse.
- reset_n low during SAVE idx=1 → busy=0, ctx_saved=0, shadows=00 immediately (asynchronous); a subsequent enter completes normally.

Source files
------------

// File: rtl/mapper_ctx_switch.sv
// Hypervisor entry/exit sequencer for the 4510 user map registers (A, X, Y, Z of map set 0).
// On entry it saves the user mapping and loads a fixed hypervisor mapping; on exit it puts the user mapping back.
module mapper_ctx_switch #(
  parameter logic [7:0] HYP_A = 8'h00,
  parameter logic [7:0] HYP_X = 8'h00,
  parameter logic [7:0] HYP_Y = 8'h00,
  parameter logic [7:0] HYP_Z = 8'h3F
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ready,
  input  logic       map_busy,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic [7:0] rd_data,
  output logic [1:0] rd_sel,
  output logic       wr_en,
  output logic [1:0] wr_sel,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ctx_saved,
  output logic [7:0] shadow_a,
  output logic [7:0] shadow_x,
  output logic [7:0] shadow_y,
  output logic [7:0] shadow_z
);

  typedef enum logic [2:0] {IDLE, SAVE, LOAD, RESTORE, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q;
  logic [7:0] shadow_q [4];
  logic [7:0] hyp_val;
  logic       step;
  logic       last;
  logic       active;
  logic       req_err;

  assign step   = ready & ~map_busy;
  assign last   = step && (idx_q == 2'd0);
  assign active = (state_q == SAVE) || (state_q == LOAD) || (state_q == RESTORE);
  assign busy   = (state_q != IDLE);

  // Register index encoding is 3=A, 2=X, 1=Y, 0=Z throughout.
  assign shadow_a = shadow_q[3];
  assign shadow_x = shadow_q[2];
  assign shadow_y = shadow_q[1];
  assign shadow_z = shadow_q[0];

  always_comb begin
    case (idx_q)
      2'd3:    hyp_val = HYP_A;
      2'd2:    hyp_val = HYP_X;
      2'd1:    hyp_val = HYP_Y;
      default: hyp_val = HYP_Z;
    endcase
  end

  // Enter wins over a simultaneous exit; the exit is dropped without an error.
  assign req_err = (state_q == IDLE) &&
                   ((enter_req && ctx_saved) || (!enter_req && exit_req && !ctx_saved));

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    rd_sel  = 2'd0;
    wr_en   = 1'b0;
    wr_sel  = 2'd0;
    wr_data = 8'h00;
    case (state_q)
      IDLE: begin
        if (enter_req && !ctx_saved)                   state_d = SAVE;
        else if (!enter_req && exit_req && ctx_saved)  state_d = RESTORE;
      end
      SAVE: begin
        rd_sel = idx_q;
        if (last) state_d = LOAD;
      end
      LOAD: begin
        wr_en   = step;
        wr_sel  = idx_q;
        wr_data = hyp_val;
        if (last) state_d = DONE;
      end
      RESTORE: begin
        wr_en   = step;
        wr_sel  = idx_q;
        wr_data = shadow_q[idx_q];
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the four-entry shadow store is reset explicitly so a partial save can never leak out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q   <= IDLE;
      idx_q     <= 2'd3;
      ctx_saved <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      done    <= ((state_q == LOAD) || (state_q == RESTORE)) && last;
      err     <= req_err;

      if (state_d != state_q)  idx_q <= 2'd3;
      else if (active && step) idx_q <= idx_q - 2'd1;

      if (state_q == SAVE && step) shadow_q[idx_q] <= rd_data;

      if (state_q == LOAD && last)         ctx_saved <= 1'b1;
      else if (state_q == RESTORE && last) ctx_saved <= 1'b0;
    end
  end

endmodule
